// File: rtl/cas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cas_pkg
// Description : Shared types for the cassette recorder: decoder FSM states,
//               measured cycle classes and status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PILOT = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } cas_state_t;

    typedef enum logic [1:0] {
        CY_NONE = 2'd0,
        CY_S    = 2'd1,
        CY_L    = 2'd2,
        CY_GAP  = 2'd3
    } cyc_class_t;

    localparam int c_stat_in_block  = 0;
    localparam int c_stat_tape_full = 1;
    localparam int c_stat_overflow  = 2;

endpackage : cas_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous FIFO with registered pointers and a
//               combinational head. A push into a full FIFO is accepted when a
//               pop happens in the same cycle. Synchronous clear wins over all.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_pop_ok;
    logic               w_push_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = r_mem[r_rptr[c_aw-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clr) r_mem[r_wptr[c_aw-1:0]] <= i_data;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/cas_recorder.sv
`default_nettype none
// ============================================================================
// Module      : cas_recorder
// Description : Demodulates the cassette-out FSK stream (S = short cycle,
//               L = long cycle), rebuilds bytes framed by start/stop bits and
//               writes them sequentially into the CAS region of SDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cas_recorder
    import cas_pkg::*;
#(
    parameter int TICK_SHORT_MAX = 6,
    parameter int TICK_LONG_MAX  = 12,
    parameter int PILOT_MIN      = 256,
    parameter int ADDR_W         = 21,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              ce_i,
    input  logic              tap_i,
    input  logic              motor_n_i,
    input  logic              rec_en_i,
    input  logic              rewind_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    input  logic              wr_ack_i,
    output logic [ADDR_W-1:0] length_o,
    output logic [2:0]        status_o
);
    localparam int c_pw  = $clog2(TICK_LONG_MAX + 2);
    localparam int c_pcw = $clog2(PILOT_MIN + 1);
    localparam logic [c_pw-1:0]  c_short_max  = c_pw'(TICK_SHORT_MAX);
    localparam logic [c_pw-1:0]  c_long_max   = c_pw'(TICK_LONG_MAX);
    localparam logic [c_pw-1:0]  c_sat        = c_pw'(TICK_LONG_MAX + 1);
    localparam logic [c_pcw-1:0] c_pilot_last = c_pcw'(PILOT_MIN - 1);

    logic               r_tap_s1, r_tap_s2, r_tap_d;
    logic               w_rise;
    logic [c_pw-1:0]    r_period;
    cyc_class_t         w_class;
    logic               w_bit_ok, w_bit_val, w_bit_err, w_half_dec, w_drop;
    logic               w_run;
    cas_state_t         r_state, w_state_nxt;
    logic [c_pcw-1:0]   r_pcnt, w_pcnt_nxt;
    logic               r_half, w_half_nxt;
    logic [2:0]         r_bcnt, w_bcnt_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_push, w_push_nxt;
    logic [ADDR_W-1:0]  r_addr, r_length;
    logic               r_tape_full, r_overflow;
    logic               w_pop, w_push_accept;
    logic               w_fifo_full, w_fifo_empty;
    logic [7:0]         w_fifo_data;

    assign w_rise = r_tap_s2 & ~r_tap_d;
    assign w_run  = ~motor_n_i & rec_en_i;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tap_s1 <= 1'b0;
            r_tap_s2 <= 1'b0;
            r_tap_d  <= 1'b0;
        end else begin
            r_tap_s1 <= tap_i;
            r_tap_s2 <= r_tap_s1;
            r_tap_d  <= r_tap_s2;
        end
    end

    // Period counter: ticks since the last rising edge, including the edge cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_period <= c_sat;
        end else if (w_rise) begin
            r_period <= ce_i ? c_pw'(1) : '0;
        end else if (ce_i && r_period != c_sat) begin
            r_period <= r_period + 1'b1;
        end
    end

    // Cycle classification and pairing of S cycles into bits.
    always_comb begin
        w_class    = CY_NONE;
        w_bit_ok   = 1'b0;
        w_bit_val  = 1'b0;
        w_bit_err  = 1'b0;
        w_half_dec = r_half;
        if (w_rise) begin
            if (r_period <= c_short_max)     w_class = CY_S;
            else if (r_period <= c_long_max) w_class = CY_L;
            else                             w_class = CY_GAP;
        end else if (ce_i && r_period == c_long_max) begin
            // The counter saturates this tick: report the gap without waiting for an edge.
            w_class = CY_GAP;
        end
        case (w_class)
            CY_S: begin
                if (r_half) begin
                    w_bit_ok   = 1'b1;
                    w_bit_val  = 1'b1;
                    w_half_dec = 1'b0;
                end else begin
                    w_half_dec = 1'b1;
                end
            end
            CY_L: begin
                w_half_dec = 1'b0;
                if (r_half) w_bit_err = 1'b1;
                else        w_bit_ok  = 1'b1;
            end
            CY_GAP:  w_half_dec = 1'b0;
            default: ;
        endcase
        w_drop = (w_class == CY_GAP) | w_bit_err;
    end

    // Decoder FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_half_nxt  = r_half;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_PILOT;
                w_pcnt_nxt  = '0;
                w_half_nxt  = 1'b0;
            end
            ST_PILOT: begin
                w_half_nxt = 1'b0;
                if (w_class == CY_S) begin
                    if (r_pcnt == c_pilot_last) begin
                        w_state_nxt = ST_SYNC;
                        w_pcnt_nxt  = '0;
                    end else begin
                        w_pcnt_nxt = r_pcnt + 1'b1;
                    end
                end else if (w_class == CY_L || w_class == CY_GAP) begin
                    w_pcnt_nxt = '0;
                end
            end
            ST_SYNC: begin
                w_half_nxt = w_half_dec;
                if (w_drop) begin
                    w_state_nxt = ST_PILOT;
                    w_half_nxt  = 1'b0;
                    w_pcnt_nxt  = '0;
                end else if (w_bit_ok && !w_bit_val) begin
                    w_state_nxt = ST_DATA;
                    w_bcnt_nxt  = 3'd0;
                end
            end
            ST_DATA: begin
                w_half_nxt = w_half_dec;
                if (w_drop) begin
                    w_state_nxt = ST_PILOT;
                    w_half_nxt  = 1'b0;
                    w_pcnt_nxt  = '0;
                end else if (w_bit_ok) begin
                    w_shift_nxt = {w_bit_val, r_shift[7:1]};
                    if (r_bcnt == 3'd7) w_state_nxt = ST_STOP;
                    else                w_bcnt_nxt  = r_bcnt + 1'b1;
                end
            end
            ST_STOP: begin
                w_half_nxt = w_half_dec;
                if (w_drop || (w_bit_ok && !w_bit_val)) begin
                    w_state_nxt = ST_PILOT;
                    w_half_nxt  = 1'b0;
                    w_pcnt_nxt  = '0;
                end else if (w_bit_ok) begin
                    w_push_nxt  = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Motor stopped or recording disarmed: abandon any partial byte.
        if (!w_run) begin
            w_state_nxt = ST_IDLE;
            w_push_nxt  = 1'b0;
            w_half_nxt  = 1'b0;
            w_pcnt_nxt  = '0;
        end
    end

    // Decoder FSM registers; rewind behaves like a synchronous reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_half  <= 1'b0;
            r_bcnt  <= 3'd0;
            r_shift <= 8'h00;
            r_push  <= 1'b0;
        end else if (rewind_i) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_half  <= 1'b0;
            r_bcnt  <= 3'd0;
            r_shift <= 8'h00;
            r_push  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_half  <= w_half_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_push  <= w_push_nxt;
        end
    end

    assign wr_req_o      = ~w_fifo_empty & ~r_tape_full;
    assign w_pop         = wr_ack_i & wr_req_o;
    assign w_push_accept = r_push & ~r_tape_full & (~w_fifo_full | w_pop);

    // Write pointer, committed length and sticky flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr      <= '0;
            r_length    <= '0;
            r_tape_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (rewind_i) begin
            r_addr      <= '0;
            r_length    <= '0;
            r_tape_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop) begin
                if (r_length != '1) r_length <= r_length + 1'b1;
                // The last address of the region is final: no wrap.
                if (r_addr == '1) r_tape_full <= 1'b1;
                else              r_addr      <= r_addr + 1'b1;
            end
            if (r_push && !w_push_accept) r_overflow <= 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .i_clr   (rewind_i),
        .i_push  (w_push_accept),
        .i_pop   (w_pop),
        .i_data  (r_shift),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign wr_addr_o = r_addr;
    assign wr_data_o = w_fifo_empty ? 8'h00 : w_fifo_data;
    assign length_o  = r_length;

    // Status word assembly.
    always_comb begin
        status_o                   = 3'b000;
        status_o[c_stat_overflow]  = r_overflow;
        status_o[c_stat_tape_full] = r_tape_full;
        status_o[c_stat_in_block]  = (r_state == ST_SYNC) || (r_state == ST_DATA) ||
                                     (r_state == ST_STOP);
    end

endmodule : cas_recorder
`default_nettype wire
